slc3_mem_responder: RTL and testbench

- Memory-side responder for the SLC-3 core's memory port. It answers the CPU's mem_mem_ena / mem_wr_ena / mem_addr / mem_wdata requests with mem_rdata after a fixed, parameterised latency.
- Backing store is an on-chip word array.
- One memory-mapped I/O word: a read returns the switches; a write drives the hex display latch.
- Out-of-range accesses are flagged as errors.

---
 rtl/slc3_mem_responder.sv | 116 +++++++++++
 tb/tb_slc3_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 memory port: fixed-latency word array,
// one switch/hex I/O word, and an error pulse for out-of-range addresses.
//
// state  | meaning
// IDLE   | waiting for mem_mem_ena; request captured on the accepting edge
// WAIT   | latency counter running down; array write commits on exit
// RESP   | mem_ready (and mem_err if out of range) high for this one cycle
module slc3_mem_responder #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [15:0]           cap_data;
  logic                  cap_wr;
  logic                  cap_io;
  logic                  cap_oor;

  logic [15:0] mem [2**ADDR_WIDTH];

  logic        hit_io;
  logic        in_range;
  logic [15:0] read_word;
  logic        commit;

  assign hit_io   = (mem_addr == IO_ADDR);
  assign in_range = (mem_addr[15:ADDR_WIDTH] == '0);
  assign busy     = (state != S_IDLE);
  assign commit   = (state == S_WAIT) && (cnt == 4'd0) && cap_wr && !cap_io && !cap_oor;

  // Reads are resolved at acceptance, so the response reflects the
  // array/switch value of that edge rather than the RESP edge.
  always_comb begin
    read_word = 16'h0000;
    if (hit_io)
      read_word = sw_i;
    else if (in_range)
      read_word = mem[mem_addr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_data  <= '0;
      cap_wr    <= 1'b0;
      cap_io    <= 1'b0;
      cap_oor   <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      hex_o     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_mem_ena) begin
            state    <= S_WAIT;
            cnt      <= LAT_M1;
            cap_idx  <= mem_addr[ADDR_WIDTH-1:0];
            cap_wr   <= mem_wr_ena;
            cap_io   <= hit_io;
            cap_oor  <= !hit_io && !in_range;
            cap_data <= mem_wr_ena ? mem_wdata : read_word;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            mem_err   <= cap_oor;
            mem_rdata <= cap_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          if (cap_wr && cap_io)
            hex_o <= cap_data;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset during WAIT forces IDLE so commit never fires.
  always_ff @(posedge clk) begin
    if (commit)
      mem[cap_idx] <= cap_data;
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed + randomized bench for slc3_mem_responder, checked against a
// word-level memory/hex model with immediate assertions.
module tb_slc3_mem_responder;

  localparam int          AW  = 10;
  localparam int          LAT = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;
  logic [15:0] sw_i;
  logic [15:0] hex_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] mm [int];
  logic [15:0] hex_m = 16'h0000;
  int          written [$];

  slc3_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .IO_ADDR(IOA)) dut (
    .clk(clk), .reset(reset), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err), .busy(busy), .sw_i(sw_i), .hex_o(hex_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_arr(input logic [15:0] a);
    return (a >> AW) == 16'h0000;
  endfunction

  // One request: drive, accept, scramble inputs during WAIT, check timing and result.
  task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] sw, input string tag);
    logic [15:0] exp_data;
    bit          exp_err;
    int          n;
    exp_err = (a != IOA) && !in_arr(a);
    if (wr) exp_data = d;
    else if (a == IOA) exp_data = sw;
    else if (exp_err) exp_data = 16'h0000;
    else exp_data = mm.exists(int'(a)) ? mm[int'(a)] : 16'hxxxx;

    @(negedge clk);
    mem_mem_ena = 1'b1; mem_wr_ena = wr; mem_addr = a; mem_wdata = d; sw_i = sw;
    @(posedge clk); #1;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'($urandom);
    mem_addr    = 16'($urandom);
    mem_wdata   = 16'($urandom);
    sw_i        = 16'($urandom);
    check({tag, "/busy_acc"}, 32'(busy), 32'd1);
    check({tag, "/rdy_acc"}, 32'(mem_ready), 32'd0);
    n = 0;
    while (!mem_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(LAT));
    check({tag, "/err"}, 32'(mem_err), 32'(exp_err));
    if (!(wr && exp_err))
      check({tag, "/rdata"}, 32'(mem_rdata), 32'(exp_data));

    if (wr && a == IOA) hex_m = d;
    else if (wr && !exp_err) begin
      mm[int'(a)] = d;
      written.push_back(int'(a));
    end

    @(posedge clk); #1;
    check({tag, "/rdy_end"}, 32'(mem_ready), 32'd0);
    check({tag, "/busy_end"}, 32'(busy), 32'd0);
    check({tag, "/hex"}, 32'(hex_o), 32'(hex_m));
  endtask

  initial begin
    int          acc [$];
    int          pulses;
    int          cyc;
    logic        pb;
    int          extra;
    int          g1;
    int          g2;
    logic [15:0] a;
    int          kind;

    reset = 1'b0; mem_mem_ena = 1'b1; mem_wr_ena = 1'b1;
    mem_addr = 16'h0005; mem_wdata = 16'hDEAD; sw_i = 16'h0000;

    // Reset held with strobe high: nothing may be accepted.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst/ready", 32'(mem_ready), 32'd0);
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/hex", 32'(hex_o), 32'h0);
      check("rst/rdata", 32'(mem_rdata), 32'h0);
    end
    @(negedge clk);
    mem_mem_ena = 1'b0;
    reset = 1'b1;

    do_req(1, 16'h0005, 16'hBEEF, 16'h0000, "wr5");
    do_req(0, 16'h0005, 16'h0000, 16'h0000, "rd5");

    do_req(1, 16'h03FF, 16'h1357, 16'h0000, "wr3ff");
    do_req(0, 16'hFFFF, 16'h0000, 16'h1234, "io_rd");
    do_req(1, 16'hFFFF, 16'h00A5, 16'h0000, "io_wr");
    do_req(0, 16'h03FF, 16'h0000, 16'h0000, "rd3ff");

    do_req(1, 16'h0000, 16'h2468, 16'h0000, "wr0");
    do_req(1, 16'h0400, 16'h5555, 16'h0000, "oor_wr");
    do_req(0, 16'h0400, 16'h0000, 16'h0000, "oor_rd");
    do_req(0, 16'h0000, 16'h0000, 16'h0000, "rd0");

    // Held strobe: three back-to-back reads of word 5.
    @(negedge clk);
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; mem_addr = 16'h0005;
    pulses = 0; cyc = 0; pb = 1'b0;
    while (pulses < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (busy && !pb) acc.push_back(cyc);
      pb = busy;
      if (mem_ready) begin
        pulses++;
        check("held/rdata", 32'(mem_rdata), 32'hBEEF);
        if (pulses == 3) mem_mem_ena = 1'b0;
      end
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_ready) extra++;
    end
    check("held/pulses", 32'(pulses + extra), 32'd3);
    check("held/accepts", 32'(acc.size()), 32'd3);
    g1 = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    g2 = (acc.size() >= 3) ? acc[2] - acc[1] : -1;
    check("held/gap1", 32'(g1), 32'(LAT + 2));
    check("held/gap2", 32'(g2), 32'(LAT + 2));

    // Reset while a write is in WAIT: write must be discarded.
    do_req(1, 16'h0010, 16'h0001, 16'h0000, "wr10");
    @(negedge clk);
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h7777;
    @(posedge clk); #1;
    mem_mem_ena = 1'b0;
    check("abort/busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort/busy_rst", 32'(busy), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort/ready", 32'(mem_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    hex_m = 16'h0000;
    check("abort/hex", 32'(hex_o), 32'h0);
    check("abort/rdata", 32'(mem_rdata), 32'h0);
    do_req(0, 16'h0010, 16'h0000, 16'h0000, "rd10");

    // Random mix against the model.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1: do_req(1, 16'($urandom_range(0, 1023)), 16'($urandom), 16'($urandom), "r_wr");
        2: do_req(0, 16'(written[$urandom_range(0, written.size() - 1)]), 16'($urandom),
                  16'($urandom), "r_rd");
        3: do_req(0, IOA, 16'($urandom), 16'($urandom), "r_iord");
        4: do_req(1, IOA, 16'($urandom), 16'($urandom), "r_iowr");
        default: begin
          a = 16'($urandom_range(1024, 16'hFFFE));
          do_req(1'($urandom), a, 16'($urandom), 16'($urandom), "r_oor");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
